// File: rtl/alu_pkg.sv
// Shared ALU definitions: data/opcode widths, opcode encodings and a helper
// that tells whether an opcode is one the ALU implements.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 6;

    localparam logic [OP_W-1:0] ADDU = 6'd0;
    localparam logic [OP_W-1:0] SUBU = 6'd1;
    localparam logic [OP_W-1:0] ORR  = 6'd2;
    localparam logic [OP_W-1:0] LUI  = 6'd3;
    localparam logic [OP_W-1:0] EQU  = 6'd4;

    function automatic logic op_is_defined(input logic [OP_W-1:0] op);
        return (op == ADDU) || (op == SUBU) || (op == ORR) ||
               (op == LUI)  || (op == EQU);
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-facing bundle of the ALU arbiter.
//   req_valid/req_ready : per-requester request handshake (bit k = requester k)
//   req_op*/req_a*/req_b*: opcode and operands of requester 0 / 1
//   rsp_valid/rsp_ready : per-requester response handshake
//   rsp_out/rsp_logic/rsp_err : registered ALU result, compare flag, bad-op flag
//   busy                : a response is being held
// master = requester side, slave = arbiter side.
interface alu_arbiter_if;
    import alu_pkg::*;

    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [OP_W-1:0]   req_op0;
    logic [OP_W-1:0]   req_op1;
    logic [DATA_W-1:0] req_a0;
    logic [DATA_W-1:0] req_a1;
    logic [DATA_W-1:0] req_b0;
    logic [DATA_W-1:0] req_b1;
    logic [1:0]        rsp_valid;
    logic [1:0]        rsp_ready;
    logic [DATA_W-1:0] rsp_out;
    logic              rsp_logic;
    logic              rsp_err;
    logic              busy;

    modport master (
        output req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1,
               rsp_ready,
        input  req_ready, rsp_valid, rsp_out, rsp_logic, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1,
               rsp_ready,
        output req_ready, rsp_valid, rsp_out, rsp_logic, rsp_err, busy
    );

endinterface

// File: rtl/alu.sv
// Combinational ALU shared by the arbiter.
//   alu_op_i        : opcode (see alu_pkg)
//   a_i, b_i        : operands
//   out_o           : arithmetic/logic result (0 for EQU and undefined ops)
//   logic_output_o  : equality flag, only meaningful for EQU
module alu
    import alu_pkg::*;
(
    input  logic [OP_W-1:0]   alu_op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] out_o,
    output logic              logic_output_o
);

    always_comb begin
        out_o          = '0;
        logic_output_o = 1'b0;
        case (alu_op_i)
            ADDU:    out_o = a_i + b_i;
            SUBU:    out_o = a_i - b_i;
            ORR:     out_o = a_i | b_i;
            LUI:     out_o = {b_i[15:0], a_i[15:0]};
            EQU:     logic_output_o = (a_i == b_i);
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, with a
// single-entry response register returned to the granted requester.
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : requester bundle (alu_arbiter_if.slave)
//
// state | meaning
// ------+----------------------------------------------
// IDLE  | response register empty, accept window open
// HOLD  | response register full, owned by own_q
module alu_arbiter
    import alu_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    alu_arbiter_if.slave bus
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]        state_q, state_d;
    logic              prio_q, prio_d;
    logic              own_q, own_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              logic_q, logic_d;
    logic              err_q, err_d;

    logic              rsp_fire;
    logic              window;
    logic [1:0]        grant;
    logic              req_fire;
    logic              sel;
    logic [OP_W-1:0]   mux_op;
    logic [DATA_W-1:0] mux_a;
    logic [DATA_W-1:0] mux_b;
    logic [DATA_W-1:0] alu_out;
    logic              alu_logic;

    // Handshake path uses only valid/ready/state/prio, never the data inputs.
    assign rsp_fire = (state_q == ST_HOLD) && bus.rsp_ready[own_q];
    assign window   = (state_q == ST_IDLE) || rsp_fire;

    always_comb begin
        grant = 2'b00;
        case (bus.req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prio_q ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
        if (!window) grant = 2'b00;
    end

    assign bus.req_ready = grant;
    assign req_fire      = |grant;
    assign sel           = grant[1];

    assign mux_op = sel ? bus.req_op1 : bus.req_op0;
    assign mux_a  = sel ? bus.req_a1  : bus.req_a0;
    assign mux_b  = sel ? bus.req_b1  : bus.req_b0;

    alu u_alu (
        .alu_op_i       (mux_op),
        .a_i            (mux_a),
        .b_i            (mux_b),
        .out_o          (alu_out),
        .logic_output_o (alu_logic)
    );

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        own_d   = own_q;
        out_d   = out_q;
        logic_d = logic_q;
        err_d   = err_q;
        if (req_fire) begin
            state_d = ST_HOLD;
            own_d   = sel;
            prio_d  = ~sel;
            out_d   = alu_out;
            logic_d = alu_logic;
            err_d   = ~op_is_defined(mux_op);
        end else if (rsp_fire) begin
            // Data is kept; only the valid is withdrawn.
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            prio_q  <= 1'b0;
            own_q   <= 1'b0;
            out_q   <= '0;
            logic_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            own_q   <= own_d;
            out_q   <= out_d;
            logic_q <= logic_d;
            err_q   <= err_d;
        end
    end

    assign bus.busy         = (state_q == ST_HOLD);
    assign bus.rsp_valid[0] = (state_q == ST_HOLD) && !own_q;
    assign bus.rsp_valid[1] = (state_q == ST_HOLD) &&  own_q;
    assign bus.rsp_out      = out_q;
    assign bus.rsp_logic    = logic_q;
    assign bus.rsp_err      = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a table of single-request vectors plus
// hand-written sequences for contention, back-to-back, stall and reset.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic clk;
    logic reset_n;

    alu_arbiter_if bus ();

    alu_arbiter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    typedef struct {
        logic        k;
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_out;
        logic        exp_logic;
        logic        exp_err;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_req(input logic k, input logic [5:0] op,
                             input logic [31:0] a, input logic [31:0] b);
        if (k) begin
            bus.req_op1 = op; bus.req_a1 = a; bus.req_b1 = b;
        end else begin
            bus.req_op0 = op; bus.req_a0 = a; bus.req_b0 = b;
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b00;
        bus.req_op0 = '0; bus.req_a0 = '0; bus.req_b0 = '0;
        bus.req_op1 = '0; bus.req_a1 = '0; bus.req_b1 = '0;

        vecs[0]  = '{1'b0, ADDU,  32'd5,         32'd7,         32'd12,        1'b0, 1'b0};
        vecs[1]  = '{1'b1, SUBU,  32'd0,         32'd1,         32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, ORR,   32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, LUI,   32'hFFFF_1234, 32'h5555_ABCD, 32'hABCD_1234, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, EQU,   32'h0000_DEAD, 32'h0000_DEAD, 32'd0,         1'b1, 1'b0};
        vecs[5]  = '{1'b1, EQU,   32'd1,         32'd2,         32'd0,         1'b0, 1'b0};
        vecs[6]  = '{1'b0, 6'd9,  32'd1,         32'd1,         32'd0,         1'b0, 1'b1};
        vecs[7]  = '{1'b1, 6'd63, 32'd1,         32'd1,         32'd0,         1'b0, 1'b1};
        vecs[8]  = '{1'b0, ADDU,  32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0, 1'b0};
        vecs[9]  = '{1'b1, 6'd5,  32'd3,         32'd3,         32'd0,         1'b0, 1'b1};
        vecs[10] = '{1'b0, SUBU,  32'd10,        32'd3,         32'd7,         1'b0, 1'b0};
        vecs[11] = '{1'b1, ORR,   32'h8000_0001, 32'h0000_0002, 32'h8000_0003, 1'b0, 1'b0};

        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        check("reset rsp_valid", {30'd0, bus.rsp_valid}, 32'd0);
        check("reset busy",      {31'd0, bus.busy},      32'd0);
        check("reset rsp_out",   bus.rsp_out,            32'd0);
        check("reset rsp_logic", {31'd0, bus.rsp_logic}, 32'd0);
        check("reset rsp_err",   {31'd0, bus.rsp_err},   32'd0);
        check("reset req_ready", {30'd0, bus.req_ready}, 32'd0);

        // Single-requester table
        for (int i = 0; i < 12; i++) begin
            drive_req(vecs[i].k, vecs[i].op, vecs[i].a, vecs[i].b);
            bus.req_valid = vecs[i].k ? 2'b10 : 2'b01;
            bus.rsp_ready = 2'b11;
            #1;
            check("tbl req_ready", {30'd0, bus.req_ready}, {30'd0, bus.req_valid});
            @(negedge clk);
            bus.req_valid = 2'b00;
            check("tbl rsp_valid", {30'd0, bus.rsp_valid},
                  vecs[i].k ? 32'd2 : 32'd1);
            check("tbl rsp_out",   bus.rsp_out, vecs[i].exp_out);
            check("tbl rsp_logic", {31'd0, bus.rsp_logic}, {31'd0, vecs[i].exp_logic});
            check("tbl rsp_err",   {31'd0, bus.rsp_err},   {31'd0, vecs[i].exp_err});
            check("tbl busy",      {31'd0, bus.busy}, 32'd1);
            @(negedge clk);
            check("tbl idle busy", {31'd0, bus.busy}, 32'd0);
        end

        // Contention from fresh reset: req0 first, then alternation
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        drive_req(1'b0, SUBU, 32'd10, 32'd3);
        drive_req(1'b1, EQU, 32'h0000_DEAD, 32'h0000_DEAD);
        bus.req_valid = 2'b11;
        bus.rsp_ready = 2'b11;
        #1;
        check("cont first grant", {30'd0, bus.req_ready}, 32'd1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c % 2 == 0) begin
                check("cont rsp_valid r0", {30'd0, bus.rsp_valid}, 32'd1);
                check("cont out r0",       bus.rsp_out, 32'd7);
                check("cont logic r0",     {31'd0, bus.rsp_logic}, 32'd0);
                check("cont grant r1",     {30'd0, bus.req_ready}, 32'd2);
            end else begin
                check("cont rsp_valid r1", {30'd0, bus.rsp_valid}, 32'd2);
                check("cont out r1",       bus.rsp_out, 32'd0);
                check("cont logic r1",     {31'd0, bus.rsp_logic}, 32'd1);
                check("cont grant r0",     {30'd0, bus.req_ready}, 32'd1);
            end
        end
        bus.req_valid = 2'b00;
        @(negedge clk);

        // Back-to-back lone requester 1
        drive_req(1'b1, LUI, 32'h0000_1234, 32'h0000_ABCD);
        bus.req_valid = 2'b10;
        bus.rsp_ready = 2'b11;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("b2b req_ready", {30'd0, bus.req_ready}, 32'd2);
            @(negedge clk);
            check("b2b rsp_out",   bus.rsp_out, 32'hABCD_1234);
            check("b2b busy",      {31'd0, bus.busy}, 32'd1);
            check("b2b rsp_valid", {30'd0, bus.rsp_valid}, 32'd2);
        end
        bus.req_valid = 2'b00;
        @(negedge clk);

        // Response stall: req0 accepted, req1 waits until owner accepts
        drive_req(1'b0, ADDU, 32'd1, 32'd2);
        drive_req(1'b1, ORR, 32'd3, 32'd4);
        bus.req_valid = 2'b01;
        bus.rsp_ready = 2'b00;
        #1;
        check("stall first grant", {30'd0, bus.req_ready}, 32'd1);
        @(negedge clk);
        bus.req_valid = 2'b10;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("stall busy",      {31'd0, bus.busy}, 32'd1);
            check("stall req_ready", {30'd0, bus.req_ready}, 32'd0);
            check("stall rsp_out",   bus.rsp_out, 32'd3);
            check("stall rsp_valid", {30'd0, bus.rsp_valid}, 32'd1);
            @(negedge clk);
        end
        bus.rsp_ready = 2'b01;
        #1;
        check("unstall grant", {30'd0, bus.req_ready}, 32'd2);
        @(negedge clk);
        bus.req_valid = 2'b00;
        check("unstall rsp_out",   bus.rsp_out, 32'd7);
        check("unstall rsp_valid", {30'd0, bus.rsp_valid}, 32'd2);

        // Reset mid-HOLD with prio left at 1
        bus.rsp_ready = 2'b11;
        @(negedge clk);
        drive_req(1'b0, ADDU, 32'd20, 32'd22);
        bus.req_valid = 2'b01;
        @(negedge clk);
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b00;
        check("pre-reset rsp_out", bus.rsp_out, 32'd42);
        #2;
        reset_n = 1'b0;
        #1;
        check("async rst rsp_valid", {30'd0, bus.rsp_valid}, 32'd0);
        check("async rst busy",      {31'd0, bus.busy}, 32'd0);
        check("async rst rsp_out",   bus.rsp_out, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        bus.req_valid = 2'b11;
        bus.rsp_ready = 2'b11;
        #1;
        check("post-reset prio", {30'd0, bus.req_ready}, 32'd1);
        @(negedge clk);
        bus.req_valid = 2'b00;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
